// File: rtl/resample18_mac.sv
// Polyphase fractional resampler MAC: drives the dual-port coefficient ROM,
// multiply-accumulates 16 taps against the sample history, and emits one
// rounded, saturated output per phase step.
module resample18_mac #(
  parameter int ACCW = 40,
  parameter int PHW  = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic [PHW-1:0] freq,
  input  logic [17:0]    din,
  input  logic           ivalid,
  output logic           iready,
  output logic [9:0]     aa,
  output logic [9:0]     ab,
  input  logic [17:0]    da,
  input  logic [17:0]    db,
  output logic [17:0]    dout,
  output logic           ovalid,
  input  logic           oready
);

  localparam logic [1:0] REQ   = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  localparam logic signed [ACCW-1:0] MAXV = ACCW'(131071);
  localparam logic signed [ACCW-1:0] MINV = ACCW'(-131072);
  localparam logic signed [ACCW-1:0] HALF = ACCW'(65536);

  logic [1:0]              state;
  logic [PHW-1:0]          phase;
  logic signed [17:0]      h [16];
  logic signed [ACCW-1:0]  acc;
  logic [2:0]              t;
  logic [1:0]              dcnt;
  // Tap index and valid flags travelling alongside the address/ROM/product stages
  logic [2:0]              ta, td;
  logic                    av, dv, pv;
  logic signed [35:0]      pa, pb;

  logic [5:0]              p;
  logic [PHW:0]            nph;
  logic signed [ACCW-1:0]  sum, rnd;
  logic [17:0]             satv;

  assign p   = phase[PHW-1 -: 6];
  assign nph = {1'b0, phase} + {1'b0, freq};

  // Accumulator next value, rounding and output saturation
  always_comb begin
    sum  = acc + $signed({{(ACCW-36){pa[35]}}, pa}) + $signed({{(ACCW-36){pb[35]}}, pb});
    rnd  = (sum + HALF) >>> 17;
    satv = rnd[17:0];
    if (rnd > MAXV) begin
      satv = 18'h1FFFF;
    end else if (rnd < MINV) begin
      satv = 18'h20000;
    end
  end

  // Control FSM, address generation, MAC pipeline and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= REQ;
      phase  <= '0;
      for (int k = 0; k < 16; k++) h[k] <= '0;
      acc    <= '0;
      t      <= '0;
      dcnt   <= '0;
      ta     <= '0;
      td     <= '0;
      av     <= 1'b0;
      dv     <= 1'b0;
      pv     <= 1'b0;
      pa     <= '0;
      pb     <= '0;
      iready <= 1'b0;
      ovalid <= 1'b0;
      dout   <= '0;
      aa     <= '0;
      ab     <= '0;
    end else if (ce) begin
      av <= (state == CALC);
      ta <= t;
      dv <= av;
      td <= ta;
      pv <= dv;
      if (dv) begin
        pa <= h[{1'b0, td}] * $signed(da);
        pb <= h[{1'b1, td}] * $signed(db);
      end
      if (pv) acc <= sum;

      case (state)
        REQ: begin
          if (!iready) begin
            iready <= 1'b1;
          end else if (ivalid) begin
            for (int k = 15; k > 0; k--) h[k] <= h[k-1];
            h[0]   <= $signed(din);
            iready <= 1'b0;
            t      <= '0;
            acc    <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          aa <= {1'b0, t, p};
          ab <= {1'b1, t, p};
          t  <= t + 3'd1;
          if (t == 3'd7) begin
            dcnt  <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          dcnt <= dcnt + 2'd1;
          // Last product lands this cycle; fold it straight into the output
          if (dcnt == 2'd2) begin
            dout   <= satv;
            ovalid <= 1'b1;
            state  <= OUT;
          end
        end
        default: begin
          if (oready) begin
            ovalid <= 1'b0;
            phase  <= nph[PHW-1:0];
            t      <= '0;
            acc    <= '0;
            state  <= nph[PHW] ? REQ : CALC;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_resample18_mac.sv
// Self-checking bench for resample18_mac: random ROM/sample stimulus, a
// sequential reference model feeding a scoreboard, and a decoupled monitor.
module tb_resample18_mac;

  logic        clk, rst, ce;
  logic [23:0] freq;
  logic [17:0] din, da, db, dout;
  logic        ivalid, iready, ovalid, oready;
  logic [9:0]  aa, ab;

  resample18_mac #(.ACCW(40), .PHW(24)) dut (
    .clk(clk), .rst(rst), .ce(ce), .freq(freq), .din(din), .ivalid(ivalid),
    .iready(iready), .aa(aa), .ab(ab), .da(da), .db(db), .dout(dout),
    .ovalid(ovalid), .oready(oready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] rom [1024];

  // Coefficient ROM: one ce-cycle read latency, shares the DUT clock enable
  always @(posedge clk) begin
    if (ce) begin
      da <= rom[aa];
      db <= rom[ab];
    end
  end

  int ncmp = 0, nfail = 0;
  logic [17:0] sq[$];
  logic [17:0] smp[$];
  logic [17:0] expq[$];
  logic [19:0] addq[$];
  bit   cer = 0, hold_on = 0, addr_on = 0, strict = 0;
  bit   in_pend = 0, lat_on = 0;
  int   lat = 0, held = 0, accepted = 0, nout_seen = 0;
  logic [19:0] last_ad = '0;
  logic [17:0] prev_dout = '0;
  bit   prev_valid = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    ncmp++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  // Reference: walk outputs in order, pulling a new sample whenever the phase wraps
  task automatic model(input int nout, input logic [23:0] f, input bit ad);
    logic signed [17:0] mh [16];
    longint ph, s, r;
    int si, pidx;
    bit need;
    logic [17:0] o18;
    ph = 0; si = 0; need = 1;
    for (int k = 0; k < 16; k++) mh[k] = '0;
    for (int o = 0; o < nout; o++) begin
      if (need) begin
        for (int k = 15; k > 0; k--) mh[k] = mh[k-1];
        mh[0] = (si < smp.size()) ? smp[si] : 18'h0;
        si++;
      end
      pidx = int'(ph >> 18);
      s = 0;
      for (int k = 0; k < 16; k++)
        s += longint'(mh[k]) * longint'($signed(rom[k*64 + pidx]));
      r = (s + 65536) >>> 17;
      if (r > 131071) r = 131071;
      if (r < -131072) r = -131072;
      o18 = r[17:0];
      expq.push_back(o18);
      if (ad) begin
        for (int t = 0; t < 8; t++) begin
          logic [2:0] t3;
          logic [5:0] p6;
          t3 = t[2:0];
          p6 = pidx[5:0];
          addq.push_back({1'b0, t3, p6, 1'b1, t3, p6});
        end
      end
      ph += longint'(f);
      need = (ph >= 64'd16777216);
      ph = ph & 64'hFFFFFF;
    end
  endtask

  // Driver: input stream, clock enable and downstream ready
  always @(negedge clk) begin
    if (rst) in_pend = 0;
    if (in_pend) begin
      sq.delete(0);
      accepted++;
      lat_on = 1;
      lat = 0;
    end
    ce = cer ? ($urandom_range(3) != 0) : 1'b1;
    if (sq.size() > 0) begin
      ivalid = 1'b1;
      din = sq[0];
    end else begin
      ivalid = 1'b0;
      din = 18'($urandom);
    end
    if (expq.size() == 0) oready = 1'b0;
    else if (hold_on && ovalid && held < 20) begin
      oready = 1'b0;
      held++;
    end else oready = cer ? 1'($urandom_range(1)) : 1'b1;
    if (ovalid && oready && ce) held = 0;
    in_pend = ivalid && iready && ce && !rst;
  end

  // Monitor: scoreboard pops, hold stability, latency, address trace
  always @(negedge clk) begin
    #1;
    if (rst) begin
      prev_valid = 0;
      lat_on = 0;
    end else begin
      if (strict) chk("no_ovalid_after_reset", {31'd0, ovalid}, 32'd0);
      if (lat_on) begin
        if (ovalid) begin
          chk("latency", lat, 11);
          lat_on = 0;
        end else if (ce) lat++;
      end
      if (ovalid) begin
        if (prev_valid) chk("dout_stable", {14'd0, dout}, {14'd0, prev_dout});
        prev_dout = dout;
        if (oready && ce) begin
          if (expq.size() > 0) begin
            chk($sformatf("dout[%0d]", nout_seen), {14'd0, dout}, {14'd0, expq[0]});
            expq.delete(0);
            nout_seen++;
          end
          prev_valid = 0;
        end else prev_valid = 1;
      end else prev_valid = 0;
      if (addr_on && {aa, ab} != last_ad) begin
        last_ad = {aa, ab};
        if (addq.size() > 0) begin
          chk("addr", {12'd0, aa, ab}, {12'd0, addq[0]});
          addq.delete(0);
        end
      end
    end
  end

  task automatic run(input int nout, input logic [23:0] f, input bit c, input bit hd,
                     input bit ad, input bit dr);
    int cyc;
    if (dr) begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
    end
    cer = c; hold_on = hd; addr_on = ad; freq = f;
    last_ad = '0; accepted = 0; held = 0; nout_seen = 0;
    expq.delete(); addq.delete();
    sq = smp;
    model(nout, f, ad);
    if (dr) rst = 1'b0;
    cyc = 0;
    while (expq.size() > 0 && cyc < 200 * nout + 200) begin
      @(negedge clk);
      cyc++;
    end
    if (expq.size() > 0) begin
      ncmp++; nfail++;
      $display("FAIL timeout outputs got %0d want %0d", nout_seen, nout);
      expq.delete();
    end
    if (ad) chk("addr_all_seen", addq.size(), 0);
    addr_on = 0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [23:0] rf;
    logic [17:0] x;
    int cyc;
    rst = 1'b1; freq = '0;
    for (int i = 0; i < 1024; i++) rom[i] = 18'($urandom);

    // Reset / idle
    repeat (3) begin
      @(negedge clk);
      chk("rst_iready", {31'd0, iready}, 32'd0);
      chk("rst_ovalid", {31'd0, ovalid}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("idle_iready", {31'd0, iready}, 32'd1);
    chk("idle_aa", {22'd0, aa}, 32'd0);
    chk("idle_ab", {22'd0, ab}, 32'd0);
    repeat (10) @(negedge clk);
    chk("idle_ovalid", {31'd0, ovalid}, 32'd0);
    chk("idle_dout", {14'd0, dout}, 32'd0);

    // Address sweep, one phase per output, zero data
    smp.delete();
    repeat (3) smp.push_back(18'h0);
    run(64, 24'h040000, 0, 0, 1, 1);
    repeat (40) @(negedge clk);
    chk("sweep_carry_accept", accepted, 2);

    // Impulse of 0.5 through a random ROM
    smp.delete();
    smp.push_back(18'h10000);
    repeat (40) smp.push_back(18'h0);
    run(24, 24'hFFFFFF, 0, 0, 0, 1);

    // Saturation, both clamp sides
    smp.delete();
    repeat (24) smp.push_back(18'h20000);
    for (int i = 0; i < 1024; i++) rom[i] = 18'h20000;
    run(20, 24'hFFFFFF, 0, 0, 0, 1);
    for (int i = 0; i < 1024; i++) rom[i] = 18'h1FFFF;
    run(20, 24'hFFFFFF, 0, 0, 0, 1);

    // Random data, same scenario with steady ce and with ce/oready jitter plus hold
    for (int i = 0; i < 1024; i++) rom[i] = 18'($urandom);
    smp.delete();
    repeat (34) smp.push_back(18'($urandom));
    rf = 24'($urandom_range(24'hFFFFFF, 24'h100000));
    run(30, rf, 0, 0, 0, 1);
    run(30, rf, 1, 1, 0, 1);
    rf = 24'($urandom_range(24'h7FFFFF, 24'h010000));
    run(20, rf, 1, 1, 1, 1);

    // Reset in the middle of CALC, then a fresh single-sample flow
    x = 18'($urandom);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    cer = 0; hold_on = 0; freq = 24'h040000;
    accepted = 0; expq.delete();
    sq.delete(); sq.push_back(x);
    rst = 1'b0;
    cyc = 0;
    while (accepted < 1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("midrst_accept", accepted, 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    strict = 1;
    repeat (30) @(negedge clk);
    strict = 0;
    smp.delete();
    smp.push_back(x);
    run(1, 24'h040000, 0, 0, 0, 0);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
